uart_byte_fifo: RTL
===================

// Module: uart_byte_fifo
// PURPOSE
//  Buffers ASCII command bytes between command_translator and uart_tx on the drive-command path.
//  command_translator emits bytes as single-cycle strobes. uart_tx is busy for a full frame per byte.
//  This block absorbs bursts and spaces bytes out on uart_tx's ready.
//  Overflow is counted, never silent.
// PARAMETERS
//  WIDTH    8   byte width
//  DEPTH    8   storage entries; power of two, >=2
//  POP_GAP  1   idle cycles forced on out_valid after each pop; 0 = back-to-back
// PORTS
//  clk         in   1                   clock, clk_50 domain
//  reset       in   1                   synchronous, active-high
//  in_data     in   WIDTH               byte from command_translator (ascii_out)
//  in_valid    in   1                   push strobe (cmd_ready)
//  in_ready    out  1                   space available
//  out_data    out  WIDTH               head byte to uart_tx (data_tx)
//  out_valid   out  1                   head valid to uart_tx (valid)
//  out_ready   in   1                   uart_tx idle (tx_ready)
//  count       out  $clog2(DEPTH+1)     current occupancy
//  overflow    out  1                   sticky: a byte was dropped
//  drop_count  out  8                   dropped bytes, saturates at 255
// BEHAVIOUR
//  Reset (sync, dominates everything):
//   - wr_ptr=rd_ptr=0, count=0, out_valid=0, out_data=0, overflow=0, drop_count=0, gap_cnt=0.
//   - in_ready=1 the cycle after reset deasserts.
//   - Stored contents are discarded, including bytes mid-burst.
//  Push: push = in_valid && in_ready.
//   - in_ready = (count != DEPTH), combinational from registered count.
//  Drop: in_valid && !in_ready.
//   - Byte is discarded, overflow <= 1, drop_count <= min(drop_count+1, 255).
//   - A pop in the same cycle does NOT rescue the byte; full is evaluated before the pop.
//  Pop: pop = out_valid && out_ready.
//   - rd_ptr advances.
//   - POP_GAP>0: gap_cnt <= POP_GAP. While gap_cnt != 0, out_valid = 0 and gap_cnt decrements each cycle.
//   - The gap gives uart_tx time to drop tx_ready, so one byte is never sent twice.
//  Output:
//   - out_valid = (count != 0) && (gap_cnt == 0).
//   - out_data = mem[rd_ptr], first-word-fall-through.
//   - out_data is held stable while out_valid=1 and not popped.
//  Latency: a push into an empty FIFO gives out_valid=1 on the next cycle, with out_data equal to that byte.
//  Simultaneous push and pop (count>=1, not full):
//   - count unchanged, both pointers advance.
//   - Order is preserved strictly FIFO.
//  Pointers: log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
//  count: count + push - pop, never exceeds DEPTH, never underflows.
//  Storage: plain register array; no reset of the array itself is required.
//  out_ready while out_valid=0: ignored, no pop.
//  overflow and drop_count clear only on reset.
// TESTING
//  - Reset, then push 0x46 ('F') with out_ready=1, POP_GAP=1:
//    out_valid=1 next cycle with out_data=0x46; popped; out_valid=0 for 1 cycle; count back to 0.
//  - out_ready=0, push 8 bytes 0x41..0x48: count=8, in_ready=0.
//    Then push 0x49 twice: overflow=1, drop_count=2, contents unchanged.
//  - Drain the full FIFO with out_ready=1:
//    bytes 0x41..0x48 in order, one pop every 2 cycles (POP_GAP=1), final count=0, out_valid=0.
//  - count=3, push and pop in the same cycle for 10 cycles:
//    count stays 3, output order matches input order, pointers wrap past 7 correctly.
//  - Full FIFO, push and pop in the same cycle:
//    pushed byte dropped, drop_count+1, count=7.
//  - 300 drops: drop_count saturates at 255.
//    Assert reset mid-burst with count=5: next cycle count=0, out_valid=0, overflow=0, drop_count=0.

Source files
------------

// File: rtl/uart_byte_fifo_if.sv
// Byte stream plus status between command_translator, the byte FIFO and uart_tx.
// The FIFO takes the slave modport; the producer/consumer side takes master.
interface uart_byte_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic [WIDTH-1:0]           in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;
  logic [7:0]                 drop_count;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, overflow, drop_count
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, overflow, drop_count
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO feeding uart_tx. Drops are counted, and
// after each pop an idle gap keeps a byte from being sent twice.
module uart_byte_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int POP_GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  uart_byte_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(POP_GAP + 2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [GW-1:0]    gap_cnt;
  logic             overflow;
  logic [7:0]       drop_count;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Full is judged on registered count, so a same-cycle pop cannot make room.
  assign push = bus.in_valid && !full;
  assign drop = bus.in_valid && full;
  assign pop  = bus.out_valid && bus.out_ready;

  assign bus.in_ready   = !full;
  assign bus.out_valid  = !empty && (gap_cnt == '0);
  assign bus.out_data   = empty ? '0 : mem[rd_ptr];
  assign bus.count      = count;
  assign bus.overflow   = overflow;
  assign bus.drop_count = drop_count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      gap_cnt    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (pop)
        gap_cnt <= GW'(POP_GAP);
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);

      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end
endmodule
